// File: rtl/tx_pkg.sv
// tx_pkg: state encoding and stop-bit range shared by the tick-paced serial transmitter.
package tx_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_e;
    localparam int STOP_MIN = 1;
    localparam int STOP_MAX = 2;
endpackage

// File: rtl/tx_shreg.sv
// tx_shreg: W-bit load/shift-right register; only the LSB leaves the block, feeding the txd mux.
module tx_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic         sh,
    input  logic [W-1:0] d,
    output logic         q0
);
    logic [W-1:0] data_q, data_d;
    always_comb data_d = clr ? '0 : ld ? d : sh ? data_q >> 1 : data_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end
    assign q0 = data_q[0];
endmodule

// File: rtl/tick_serial_tx.sv
// tick_serial_tx: tick-paced async-serial transmitter (start, W data LSB first, optional even parity, stop bits).
module tick_serial_tx
    import tx_pkg::*;
#(
    parameter int W         = 8,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         clr,
    input  logic         tx_valid,
    input  logic [W-1:0] tx_data,
    output logic         tx_ready,
    output logic         txd,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(W + 1);
    localparam int SB = (STOP_BITS > STOP_MAX) ? STOP_MAX : (STOP_BITS < STOP_MIN) ? STOP_MIN : STOP_BITS;
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic STP_LAST = 1'(SB - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stp_q, stp_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ld, sh, sr0;

    tx_shreg #(.W(W)) u_shreg (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .ld (ld),
        .sh (sh),
        .d  (tx_data),
        .q0 (sr0)
    );

    // Each data bit is launched into txd_q and shifted out of the register on the same tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stp_d   = stp_q;
        par_d   = par_q;
        txd_d   = txd_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ld      = 1'b0;
        sh      = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            stp_d   = 1'b0;
            txd_d   = 1'b1;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_d = 1'b1;
                    rdy_d = 1'b1;
                    if (tx_valid && rdy_q) begin
                        ld      = 1'b1;
                        par_d   = ^tx_data;
                        state_d = ALIGN;
                        rdy_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                ALIGN: if (tick) begin
                    state_d = START;
                    txd_d   = 1'b0;
                end
                START: if (tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    txd_d   = sr0;
                    sh      = 1'b1;
                end
                DATA: if (tick) begin
                    if (cnt_q == LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        txd_d   = (PARITY_EN != 0) ? par_q : 1'b1;
                        stp_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        txd_d = sr0;
                        sh    = 1'b1;
                    end
                end
                PARITY: if (tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    stp_d   = 1'b0;
                end
                STOP: if (tick) begin
                    if (stp_q == STP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stp_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stp_q   <= 1'b0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stp_q   <= stp_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = rdy_q;
    assign txd      = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_tick_serial_tx.sv
// tb_tick_serial_tx: directed scoreboard bench; u0 is 8/parity/1-stop, u1 is 8/no-parity/2-stop.
module tb_tick_serial_tx;
    logic       clk = 1'b0, rst = 1'b1, clr = 1'b0, tick_hi = 1'b0;
    logic       tick;
    logic [7:0] tx_data = 8'h00;
    logic       va = 1'b0, vb = 1'b0;
    logic       a_rdy, a_txd, a_busy, a_done;
    logic       b_rdy, b_txd, b_busy, b_done;
    logic       txd_s, rdy_s, busy_s, done_s;
    logic       tick_s = 1'b0;
    logic       sel = 1'b0;
    logic       q_exp[$];
    int         total = 0, bad = 0;
    int         div = 0, cyc = 0, a_dn = 0, b_dn = 0;
    int         dn0 = 0, t_acc = 0, t_first = 0, t_done = 0;

    tick_serial_tx #(.W(8), .PARITY_EN(1), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tick(tick), .clr(clr), .tx_valid(va), .tx_data(tx_data),
        .tx_ready(a_rdy), .txd(a_txd), .busy(a_busy), .done(a_done)
    );
    tick_serial_tx #(.W(8), .PARITY_EN(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .tick(tick), .clr(clr), .tx_valid(vb), .tx_data(tx_data),
        .tx_ready(b_rdy), .txd(b_txd), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;
    assign tick   = tick_hi | (div == 5);
    assign txd_s  = sel ? b_txd  : a_txd;
    assign rdy_s  = sel ? b_rdy  : a_rdy;
    assign busy_s = sel ? b_busy : a_busy;
    assign done_s = sel ? b_done : a_done;

    always @(posedge clk) begin
        div    <= (div == 5) ? 0 : div + 1;
        tick_s <= tick;
        cyc    <= cyc + 1;
        if (a_done) a_dn <= a_dn + 1;
        if (b_done) b_dn <= b_dn + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t beyond limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        q_exp.push_back(1'b0);
        for (int i = 0; i < 8; i++) q_exp.push_back(d[i]);
        if (!sel) q_exp.push_back(^d);
        repeat (sel ? 2 : 1) q_exp.push_back(1'b1);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!tick_s && n < 40);
        chk("tick_wait", {31'd0, tick_s}, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input bit align);
        int n = 0;
        @(negedge clk);
        while (align && !tick && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rdy", {31'd0, rdy_s}, 32'd1);
        dn0     = sel ? b_dn : a_dn;
        tx_data = d;
        if (sel) vb = 1'b1;
        else     va = 1'b1;
        push_frame(d);
        @(posedge clk);
        #1;
        va    = 1'b0;
        vb    = 1'b0;
        t_acc = cyc;
        chk("acc_busy", {31'd0, busy_s}, 32'd1);
        chk("acc_rdy", {31'd0, rdy_s}, 32'd0);
        chk("acc_txd", {31'd0, txd_s}, 32'd1);
    endtask

    task automatic run_bits(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            if (i == 0) t_first = cyc;
            chk(tag, {31'd0, txd_s}, {31'd0, q_exp.pop_front()});
            chk("bit_busy", {31'd0, busy_s}, 32'd1);
            chk("bit_rdy", {31'd0, rdy_s}, 32'd0);
            chk("bit_nodone", {31'd0, done_s}, 32'd0);
        end
    endtask

    task automatic run_done(input string tag);
        wait_tick();
        t_done = cyc;
        chk({tag, "_done"}, {31'd0, done_s}, 32'd1);
        chk("done_txd", {31'd0, txd_s}, 32'd1);
        chk("done_rdy", {31'd0, rdy_s}, 32'd0);
        chk("done_busy", {31'd0, busy_s}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_done", {31'd0, done_s}, 32'd0);
        chk("post_rdy", {31'd0, rdy_s}, 32'd1);
        chk("done_cnt", (sel ? b_dn : a_dn) - dn0, 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_a_txd", {31'd0, a_txd}, 32'd1);
        chk("rst_a_rdy", {31'd0, a_rdy}, 32'd1);
        chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_a_done", {31'd0, a_done}, 32'd0);
        chk("rst_b_txd", {31'd0, b_txd}, 32'd1);
        chk("rst_b_rdy", {31'd0, b_rdy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        sel = 1'b0;
        send(8'hA5, 1'b0);
        run_bits(11, "t1_bit");
        run_done("t1");
        chk("t1_span", t_done - t_first, 32'd66);

        send(8'h01, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t2_hold", {31'd0, txd_s}, 32'd1);
        end
        run_bits(11, "t2_bit");
        chk("t2_align", t_first - t_acc, 32'd6);
        run_done("t2");

        sel = 1'b1;
        @(negedge clk);
        chk("t3_pre_rdy", {31'd0, rdy_s}, 32'd1);
        dn0     = b_dn;
        tx_data = 8'hFF;
        vb      = 1'b1;
        push_frame(8'hFF);
        @(posedge clk);
        #1;
        chk("t3_acc1", {31'd0, busy_s}, 32'd1);
        tx_data = 8'h00;
        run_bits(11, "t3a_bit");
        run_done("t3a");
        chk("t3a_span", t_done - t_first, 32'd66);
        push_frame(8'h00);
        dn0 = b_dn;
        @(posedge clk);
        #1;
        chk("t3_acc2_rdy", {31'd0, rdy_s}, 32'd0);
        chk("t3_acc2_busy", {31'd0, busy_s}, 32'd1);
        vb = 1'b0;
        run_bits(11, "t3b_bit");
        run_done("t3b");
        chk("t3b_span", t_done - t_first, 32'd66);

        sel = 1'b0;
        send(8'h3C, 1'b0);
        run_bits(5, "t4_bit");
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("t4_txd", {31'd0, txd_s}, 32'd1);
        chk("t4_busy", {31'd0, busy_s}, 32'd0);
        chk("t4_rdy", {31'd0, rdy_s}, 32'd1);
        q_exp.delete();
        repeat (14) @(posedge clk);
        #1;
        chk("t4_idle_txd", {31'd0, txd_s}, 32'd1);
        chk("t4_nodone", a_dn - dn0, 32'd0);
        send(8'h5A, 1'b0);
        run_bits(11, "t4_next");
        run_done("t4");

        send(8'hC3, 1'b0);
        run_bits(11, "t5_bit");
        #3;
        rst = 1'b1;
        #1;
        chk("t5_txd", {31'd0, txd_s}, 32'd1);
        chk("t5_rdy", {31'd0, rdy_s}, 32'd1);
        chk("t5_busy", {31'd0, busy_s}, 32'd0);
        chk("t5_done", {31'd0, done_s}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_nodone", a_dn - dn0, 32'd0);
        chk("t5_idle", {31'd0, txd_s}, 32'd1);

        @(negedge clk);
        tick_hi = 1'b1;
        send(8'h80, 1'b0);
        run_bits(11, "t6_bit");
        chk("t6_first", t_first - t_acc, 32'd1);
        run_done("t6");
        chk("t6_span", t_done - t_first, 32'd11);
        tick_hi = 1'b0;
        chk("q_empty", q_exp.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
